// File: rtl/dtree_pkg.sv
// rtl/dtree_pkg.sv - shared types and widths for the dtree front-end scheduler
package dtree_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} sched_state_t;

  localparam int DTREE_LEVEL_W = 2;
  localparam int DTREE_PATH_W  = 2;
  localparam int DROP_COUNT_W  = 16;

endpackage

// File: rtl/dtree_rr_arbiter.sv
// rtl/dtree_rr_arbiter.sv - combinational first-pending search starting at rr_ptr, with wrap
module dtree_rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int CH_WIDTH = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] pending,
  input  logic [CH_WIDTH-1:0] rr_ptr,
  output logic [CH_WIDTH-1:0] grant,
  output logic                any
);

  logic [CH_WIDTH-1:0] cand;

  // Walk from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      cand = CH_WIDTH'((int'(rr_ptr) + i) % CHANNELS);
      if (pending[cand]) begin
        grant = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtree_scheduler.sv
// rtl/dtree_scheduler.sv - per-channel vector buffers, round-robin issue to dtree, result tagging
// Optional DTREE_SCHED_DROP_COUNT_EN adds drop_count for samples offered to a pending channel.
module dtree_scheduler
  import dtree_pkg::*;
#(
  parameter int FEATURES = 3,
  parameter int IN_WIDTH = 10,
  parameter int CHANNELS = 4,
  parameter int CH_WIDTH = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          ch_valid,
  input  logic [CHANNELS*IN_WIDTH-1:0] ch_sample,
  output logic [CHANNELS-1:0]          ch_ready,
  input  logic                         dt_ready,
  output logic                         dt_valid,
  output logic [IN_WIDTH-1:0]          dt_sample,
  output logic [CH_WIDTH-1:0]          dt_channel,
  input  logic                         dt_out_valid,
  input  logic [DTREE_LEVEL_W-1:0]     dt_level,
  input  logic [DTREE_PATH_W-1:0]      dt_path,
  output logic                         res_valid,
  output logic [CH_WIDTH-1:0]          res_channel,
  output logic [DTREE_LEVEL_W-1:0]     res_level,
  output logic [DTREE_PATH_W-1:0]      res_path,
  output logic                         busy
`ifdef DTREE_SCHED_DROP_COUNT_EN
  ,
  output logic [DROP_COUNT_W-1:0]      drop_count
`endif
);

  localparam int IDX_W = (FEATURES > 1) ? $clog2(FEATURES) : 1;

  sched_state_t        state, state_next;
  logic [CHANNELS-1:0] pending;
  logic [IDX_W-1:0]    fill [CHANNELS];
  logic [IN_WIDTH-1:0] sample_buf [CHANNELS][FEATURES];
  logic [IDX_W-1:0]    idx;
  logic [CH_WIDTH-1:0] rr_ptr, grant;
  logic                any_pending, grant_load, issue_fire, issue_last, res_load;

  dtree_rr_arbiter #(.CHANNELS(CHANNELS), .CH_WIDTH(CH_WIDTH)) u_arb (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .grant   (grant),
    .any     (any_pending)
  );

  assign ch_ready = ~pending;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_load = 1'b0;
    issue_fire = 1'b0;
    issue_last = 1'b0;
    res_load   = 1'b0;
    case (state)
      IDLE: begin
        if (any_pending) begin
          grant_load = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (dt_ready) begin
          issue_fire = 1'b1;
          if (idx == IDX_W'(FEATURES - 1)) begin
            issue_last = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dt_out_valid) begin
          res_load   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      rr_ptr      <= '0;
      dt_channel  <= '0;
      dt_valid    <= 1'b0;
      dt_sample   <= '0;
      res_valid   <= 1'b0;
      res_channel <= '0;
      res_level   <= '0;
      res_path    <= '0;
    end else begin
      dt_valid  <= issue_fire;
      res_valid <= res_load;
      if (grant_load) begin
        dt_channel <= grant;
        idx        <= '0;
      end
      if (issue_fire) begin
        dt_sample <= sample_buf[dt_channel][idx];
        idx       <= idx + 1'b1;
      end
      if (issue_last)
        rr_ptr <= (dt_channel == CH_WIDTH'(CHANNELS - 1)) ? '0 : dt_channel + 1'b1;
      if (res_load) begin
        res_channel <= dt_channel;
        res_level   <= dt_level;
        res_path    <= dt_path;
      end
    end
  end

  // Set and clear of a pending flag never coincide: accepts only happen while it is clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      for (int c = 0; c < CHANNELS; c++) fill[c] <= '0;
    end else begin
      if (issue_last) pending[dt_channel] <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_valid[c] && !pending[c]) begin
          if (fill[c] == IDX_W'(FEATURES - 1)) begin
            fill[c]    <= '0;
            pending[c] <= 1'b1;
          end else begin
            fill[c] <= fill[c] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++)
      if (ch_valid[c] && !pending[c])
        sample_buf[c][fill[c]] <= ch_sample[c*IN_WIDTH +: IN_WIDTH];
  end

`ifdef DTREE_SCHED_DROP_COUNT_EN
  localparam int DSUM_W = DROP_COUNT_W + 1;
  logic [DSUM_W-1:0] drop_sum;

  always_comb drop_sum = {1'b0, drop_count} + DSUM_W'($countones(ch_valid & pending));

  always_ff @(posedge clk) begin
    if (reset)                      drop_count <= '0;
    else if (drop_sum[DSUM_W-1])    drop_count <= '1;
    else                            drop_count <= drop_sum[DROP_COUNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_dtree_scheduler.sv
// tb/tb_dtree_scheduler.sv - scoreboard bench for dtree_scheduler (DTREE_SCHED_DROP_COUNT_EN optional)
module tb_dtree_scheduler;
  localparam int FEATURES = 3;
  localparam int IN_WIDTH = 10;
  localparam int CHANNELS = 4;
  localparam int CH_WIDTH = 2;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic [CHANNELS-1:0]          ch_valid = '0;
  logic [CHANNELS*IN_WIDTH-1:0] ch_sample = '0;
  logic [CHANNELS-1:0]          ch_ready;
  logic                         dt_ready = 1'b1;
  logic                         dt_valid;
  logic [IN_WIDTH-1:0]          dt_sample;
  logic [CH_WIDTH-1:0]          dt_channel;
  logic                         dt_out_valid = 1'b0;
  logic [1:0]                   dt_level = '0;
  logic [1:0]                   dt_path = '0;
  logic                         res_valid;
  logic [CH_WIDTH-1:0]          res_channel;
  logic [1:0]                   res_level;
  logic [1:0]                   res_path;
  logic                         busy;
`ifdef DTREE_SCHED_DROP_COUNT_EN
  logic [15:0]                  drop_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_dt[$];
  logic [5:0]  exp_res[$];
  logic [11:0] mon_dt_e;
  logic [5:0]  mon_res_e;
  logic        auto_resp = 1'b0;
  int          resp_cnt = 0;
  logic [1:0]  resp_ch;

  dtree_scheduler #(.FEATURES(FEATURES), .IN_WIDTH(IN_WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk          (clk),
    .reset        (reset),
    .ch_valid     (ch_valid),
    .ch_sample    (ch_sample),
    .ch_ready     (ch_ready),
    .dt_ready     (dt_ready),
    .dt_valid     (dt_valid),
    .dt_sample    (dt_sample),
    .dt_channel   (dt_channel),
    .dt_out_valid (dt_out_valid),
    .dt_level     (dt_level),
    .dt_path      (dt_path),
    .res_valid    (res_valid),
    .res_channel  (res_channel),
    .res_level    (res_level),
    .res_path     (res_path),
    .busy         (busy)
`ifdef DTREE_SCHED_DROP_COUNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every issued sample and every tagged result must match the head of its queue.
  always @(negedge clk) begin
    if (!reset && dt_valid) begin
      checks++;
      if (exp_dt.size() == 0) begin
        errors++;
        $display("FAIL dt_issue unexpected: got ch %0d sample %0d, required no issue", dt_channel, dt_sample);
      end else begin
        mon_dt_e = exp_dt.pop_front();
        if ({dt_channel, dt_sample} !== mon_dt_e) begin
          errors++;
          $display("FAIL dt_issue: got ch %0d sample %0d, required ch %0d sample %0d",
                   dt_channel, dt_sample, mon_dt_e[11:10], mon_dt_e[9:0]);
        end
      end
    end
    if (!reset && res_valid) begin
      checks++;
      if (exp_res.size() == 0) begin
        errors++;
        $display("FAIL res unexpected: got ch %0d level %0d path %0d, required no result",
                 res_channel, res_level, res_path);
      end else begin
        mon_res_e = exp_res.pop_front();
        if ({res_channel, res_level, res_path} !== mon_res_e) begin
          errors++;
          $display("FAIL res: got ch %0d level %0d path %0d, required ch %0d level %0d path %0d",
                   res_channel, res_level, res_path, mon_res_e[5:4], mon_res_e[3:2], mon_res_e[1:0]);
        end
      end
    end
  end

  // Auto dtree model: two cycles after a full vector, answer with level=ch, path=~ch.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) resp_cnt = 0;
      else if (dt_valid) begin
        resp_cnt++;
        if (resp_cnt == FEATURES) begin
          resp_cnt = 0;
          resp_ch  = dt_channel;
          if (auto_resp) begin
            repeat (2) @(posedge clk);
            #1;
            dt_out_valid = 1'b1;
            dt_level     = resp_ch;
            dt_path      = ~resp_ch;
            @(posedge clk);
            #1;
            dt_out_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ch_valid = '0; dt_out_valid = 1'b0; dt_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic push_vec(input int c, input int b0);
    for (int k = 0; k < FEATURES; k++) exp_dt.push_back({2'(c), 10'(b0 + 16 * c + k)});
  endtask

  task automatic push_res(input int c);
    exp_res.push_back({2'(c), 2'(c), ~2'(c)});
  endtask

  task automatic feed(input logic [3:0] mask, input int b0);
    for (int k = 0; k < FEATURES; k++) begin
      for (int c = 0; c < CHANNELS; c++) ch_sample[c*IN_WIDTH +: IN_WIDTH] = 10'(b0 + 16 * c + k);
      ch_valid = mask;
      tick();
    end
    ch_valid = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_dt.size() != 0 || exp_res.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s drain: %0d samples and %0d results still outstanding, required 0",
               name, exp_dt.size(), exp_res.size());
      exp_dt.delete();
      exp_res.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks += 6;
    if (dt_valid !== 1'b0 || dt_sample !== '0 || dt_channel !== '0) begin
      errors++; $display("FAIL reset_dt: got valid %b sample %0d ch %0d, required 0 0 0", dt_valid, dt_sample, dt_channel);
    end
    if (res_valid !== 1'b0 || res_channel !== '0) begin
      errors++; $display("FAIL reset_res: got valid %b ch %0d, required 0 0", res_valid, res_channel);
    end
    if (res_level !== '0 || res_path !== '0) begin
      errors++; $display("FAIL reset_res_data: got level %0d path %0d, required 0 0", res_level, res_path);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (ch_ready !== 4'hF) begin errors++; $display("FAIL reset_ch_ready: got %b, required 1111", ch_ready); end
`ifdef DTREE_SCHED_DROP_COUNT_EN
    if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d, required 0", drop_count); end
`else
    if (dt_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b, required 0", dt_valid); end
`endif
  endtask

  task automatic test_single();
    auto_resp = 1'b0;
    push_vec(0, 5);
    feed(4'b0001, 5);
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_grant_edge: busy %b, required 0", busy); end
    if (ch_ready[0] !== 1'b0) begin errors++; $display("FAIL single_pending: ch_ready0 %b, required 0", ch_ready[0]); end
    @(negedge clk);
    checks++;
    if (dt_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_latency: valid %b busy %b, required 0 1", dt_valid, busy);
    end
    for (int k = 0; k < FEATURES; k++) begin
      @(negedge clk);
      checks++;
      if (dt_valid !== 1'b1) begin errors++; $display("FAIL single_consecutive %0d: valid %b, required 1", k, dt_valid); end
    end
    @(negedge clk);
    checks++;
    if (dt_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_wait: valid %b busy %b, required 0 1", dt_valid, busy);
    end
    exp_res.push_back({2'd0, 2'd2, 2'b01});
    dt_out_valid = 1'b1; dt_level = 2'd2; dt_path = 2'b01;
    tick();
    dt_out_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_channel !== 2'd0 || res_level !== 2'd2 || res_path !== 2'b01) begin
      errors++; $display("FAIL single_res: valid %b ch %0d level %0d path %0d, required 1 0 2 1",
                         res_valid, res_channel, res_level, res_path);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_res_pulse: valid %b busy %b, required 0 0", res_valid, busy);
    end
    drain("single");
  endtask

  task automatic test_idle_out_valid();
    dt_out_valid = 1'b1; dt_level = 2'd3; dt_path = 2'd3;
    tick();
    dt_out_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL idle_out_valid: res_valid %b busy %b, required 0 0", res_valid, busy);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    auto_resp = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin push_vec(c, 100); push_res(c); end
    feed(4'hF, 100);
    drain("rr_all");
    push_vec(2, 200); push_res(2);
    feed(4'b0100, 200);
    drain("rr_refill2");
    push_vec(3, 300); push_vec(0, 300); push_res(3); push_res(0);
    feed(4'b1001, 300);
    drain("rr_wrap");
  endtask

  task automatic test_back_to_back();
    push_vec(0, 400); push_vec(1, 400); push_res(0); push_res(1);
    for (int k = 0; k < FEATURES + 1; k++) begin
      ch_sample[0 +: IN_WIDTH]        = 10'(400 + k);
      ch_sample[IN_WIDTH +: IN_WIDTH] = 10'(416 + k - 1);
      ch_valid = {2'b00, k >= 1, k < FEATURES};
      tick();
    end
    ch_valid = '0;
    drain("back_to_back");
  endtask

  task automatic test_stall();
    int n = 0;
    push_vec(3, 500); push_res(3);
    feed(4'b1000, 500);
    while (!dt_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL stall_start: dt_valid never seen, required within 50 cycles"); end
    dt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (dt_valid !== 1'b0) begin errors++; $display("FAIL stall_hold %0d: valid %b, required 0", k, dt_valid); end
    end
    dt_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (dt_valid !== 1'b1) begin errors++; $display("FAIL stall_resume %0d: valid %b, required 1", k, dt_valid); end
    end
    drain("stall");
  endtask

  task automatic test_pending_hold();
    do_reset();
    auto_resp = 1'b1;
    push_vec(1, 100); push_res(1);
    for (int k = 0; k < FEATURES + 4; k++) begin
      ch_sample[IN_WIDTH +: IN_WIDTH] = (k < FEATURES) ? 10'(116 + k) : 10'(900 + k);
      ch_valid = 4'b0010;
      if (k >= FEATURES) begin
        checks++;
        if (ch_ready[1] !== 1'b0) begin errors++; $display("FAIL pending_ready %0d: got %b, required 0", k, ch_ready[1]); end
      end
      tick();
    end
    ch_valid = '0;
    drain("pending_hold");
    checks++;
    if (ch_ready[1] !== 1'b1) begin errors++; $display("FAIL pending_release: ch_ready1 %b, required 1", ch_ready[1]); end
`ifdef DTREE_SCHED_DROP_COUNT_EN
    checks++;
    if (drop_count !== 16'd4) begin errors++; $display("FAIL drop_count: got %0d, required 4", drop_count); end
`endif
    push_vec(1, 30); push_res(1);
    feed(4'b0010, 30);
    drain("pending_refill");
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    auto_resp = 1'b0;
    push_vec(2, 40);
    feed(4'b0100, 40);
    while (exp_dt.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || n >= 50) begin errors++; $display("FAIL rst_wait_reach: busy %b, required 1", busy); end
    tick();
    ch_sample[0 +: IN_WIDTH] = 10'd999;
    ch_valid = 4'b0001;
    repeat (2) tick();
    ch_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks += 3;
    if (dt_valid !== 1'b0 || dt_sample !== '0 || dt_channel !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_wait_dt: valid %b sample %0d ch %0d busy %b, required 0 0 0 0",
                         dt_valid, dt_sample, dt_channel, busy);
    end
    if (res_valid !== 1'b0 || res_channel !== '0 || res_level !== '0 || res_path !== '0) begin
      errors++; $display("FAIL rst_wait_res: valid %b ch %0d level %0d path %0d, required 0 0 0 0",
                         res_valid, res_channel, res_level, res_path);
    end
    if (ch_ready !== 4'hF) begin errors++; $display("FAIL rst_wait_ready: got %b, required 1111", ch_ready); end
    dt_out_valid = 1'b1; dt_level = 2'd1; dt_path = 2'd2;
    tick();
    dt_out_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_stale %0d: res_valid %b, required 0", k, res_valid); end
    end
    auto_resp = 1'b1;
    push_vec(0, 31); push_res(0);
    feed(4'b0001, 31);
    drain("rst_partial_discard");
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle_out_valid();
    test_round_robin();
    test_back_to_back();
    test_stall();
    test_pending_hold();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
